// File: rtl/alu_seq_param.sv
// alu_seq_param -- registered, handshaked ALU for the CPU datapath, sitting
// between the register-file read stage and writeback.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : ALUOp 111 is an unsigned iterative shift-add multiply taking
//               WIDTH cycles in a dedicated MUL state.
//   undefined : no MUL state or multiplier registers; ALUOp 111 completes in
//               one cycle with Result=0, Zero=1, Overflow=0, CarryOut=0.
//
// Parameters:
//   WIDTH  datapath width (>= 4, power of 2); SHW = log2(WIDTH) is derived.
//
// Ports:
//   Clock     rising-edge clock
//   Reset     synchronous active-high reset
//   InValid   operands/op presented        InReady   block can accept now
//   A, B      operands                     ALUOp     operation select
//   AInvert   use ~A (AND/OR/ADD/SLT)      BNegate   use ~B, carry-in 1
//   OutValid  result/flags valid           OutReady  consumer takes result
//   Result    registered result            Zero      Result == 0
//   Overflow  signed overflow              CarryOut  carry / shifted-out bit /
//                                                    product-high nonzero
`default_nettype none

module alu_seq_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  input  logic             AInvert,
  input  logic             BNegate,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  op_e              op;
  logic             accept;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH:0]   sra_w;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             co_c;

  assign op     = op_e'(ALUOp);
  assign accept = InValid & InReady;

  // Single-cycle datapath, evaluated on the live inputs at acceptance.
  always_comb begin
    a_c = AInvert ? ~A : A;
    b_c = BNegate ? ~B : B;
    sum = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, BNegate};
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    add_ovf = (a_c[WIDTH-1] ^ b_c[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
    amt = B[SHW-1:0];
    // Each shift runs on a one-bit-wider vector so the extra bit catches the
    // last bit shifted out (and stays 0 for a zero amount).
    sll_w = {1'b0, A} << amt;
    srl_w = {A, 1'b0} >> amt;
    sra_w = $signed({A, 1'b0}) >>> amt;

    res_c = '0;
    ovf_c = 1'b0;
    co_c  = 1'b0;
    case (op)
      OP_AND: res_c = a_c & b_c;
      OP_OR:  res_c = a_c | b_c;
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        ovf_c = add_ovf;
        co_c  = sum[WIDTH];
      end
      OP_SLT: begin
        res_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        ovf_c = add_ovf;
        co_c  = sum[WIDTH];
      end
      OP_SLL: begin
        res_c = sll_w[WIDTH-1:0];
        co_c  = sll_w[WIDTH];
      end
      OP_SRL: begin
        res_c = srl_w[WIDTH:1];
        co_c  = srl_w[0];
      end
      OP_SRA: begin
        res_c = sra_w[WIDTH:1];
        co_c  = sra_w[0];
      end
      default: begin
        res_c = '0;
        ovf_c = 1'b0;
        co_c  = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;

  assign InReady   = (state == S_IDLE) & (~OutValid | OutReady);
  assign prod_next = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      OutValid <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              // Any previous result was consumed this cycle (InReady implies it).
              state    <= S_MUL;
              cnt      <= '0;
              mcand    <= {{WIDTH{1'b0}}, A};
              mplier   <= B;
              prod     <= '0;
              OutValid <= 1'b0;
            end else begin
              Result   <= res_c;
              Zero     <= (res_c == '0);
              Overflow <= ovf_c;
              CarryOut <= co_c;
              OutValid <= 1'b1;
            end
          end else if (OutReady) begin
            OutValid <= 1'b0;
          end
        end
        S_MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            Result   <= prod_next[WIDTH-1:0];
            Zero     <= (prod_next[WIDTH-1:0] == '0);
            Overflow <= 1'b0;
            CarryOut <= |prod_next[2*WIDTH-1:WIDTH];
            OutValid <= 1'b1;
            cnt      <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`else

  assign InReady = ~OutValid | OutReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      OutValid <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else if (accept) begin
      Result   <= res_c;
      Zero     <= (res_c == '0);
      Overflow <= ovf_c;
      CarryOut <= co_c;
      OutValid <= 1'b1;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_param.sv
module tb_alu_seq_param;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALUOp;
  logic         AInvert;
  logic         BNegate;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic         Zero;
  logic         Overflow;
  logic         CarryOut;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         c;
  } exp_t;

  alu_seq_param #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .AInvert  (AInvert),
    .BNegate  (BNegate),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow),
    .CarryOut (CarryOut)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b,
                                 input logic ai, bn);
    longint m, ra, rb, ca, cb, sa, sb, s, ss, res, sraw, p;
    int     n;
    exp_t   e;
    m  = longint'(1) << W;
    ra = longint'(a);
    rb = longint'(b);
    ca = ai ? (m - 1 - ra) : ra;
    cb = bn ? (m - 1 - rb) : rb;
    sa = (ca >= m / 2) ? ca - m : ca;
    sb = (cb >= m / 2) ? cb - m : cb;
    n  = int'(rb % W);
    e.o = 1'b0;
    e.c = 1'b0;
    res = 0;
    case (op)
      3'd0: res = ca & cb;
      3'd1: res = ca | cb;
      3'd2, 3'd3: begin
        s   = ca + cb + longint'(bn);
        ss  = sa + sb + longint'(bn);
        e.c = (s >= m);
        e.o = (ss >= m / 2) || (ss < -(m / 2));
        res = (op == 3'd3) ? ((ss < 0) ? 1 : 0) : (s % m);
      end
      3'd4: begin
        res = (ra << n) % m;
        e.c = (n == 0) ? 1'b0 : (((ra >> (W - n)) & 1) != 0);
      end
      3'd5: begin
        res = ra >> n;
        e.c = (n == 0) ? 1'b0 : (((ra >> (n - 1)) & 1) != 0);
      end
      3'd6: begin
        sraw = (ra >= m / 2) ? ra - m : ra;
        res  = (sraw >>> n) & (m - 1);
        e.c  = (n == 0) ? 1'b0 : (((ra >> (n - 1)) & 1) != 0);
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        p   = ra * rb;
        res = p % m;
        e.c = ((p / m) != 0);
`else
        p   = 0;
        res = p;
`endif
      end
    endcase
    e.r = res[W-1:0];
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    return (op == 3'd7) ? W + 1 : 1;
`else
    return (op == 3'd7) ? 1 : 1;
`endif
  endfunction

  // Presents one op at the current negedge with OutReady=1, scrambles the
  // inputs after acceptance, and waits (bounded) for OutValid.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic ai, bn,
                       output exp_t got, output int lat, output int busy_ready);
    int guard = 0;
    OutReady = 1'b1;
    while (!InReady && guard < 100) begin
      @(negedge Clock);
      guard++;
    end
    ALUOp = op; A = a; B = b; AInvert = ai; BNegate = bn; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    A = W'($urandom); B = W'($urandom); ALUOp = 3'($urandom);
    AInvert = 1'($urandom); BNegate = 1'($urandom);
    lat = 1;
    busy_ready = 0;
    while (!OutValid && lat < 100) begin
      if (InReady) busy_ready++;
      @(negedge Clock);
      lat++;
    end
    got = {Result, Zero, Overflow, CarryOut};
  endtask

  task automatic drain();
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    A = '0; B = '0; ALUOp = '0; AInvert = 1'b0; BNegate = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if ({OutValid, Result, Zero, Overflow, CarryOut, InReady} !== {1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got OutValid=%b Result=%h Z=%b O=%b C=%b InReady=%b, want 0 0000 1 0 0 1",
               OutValid, Result, Zero, Overflow, CarryOut, InReady);
    end
  endtask

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ai;
    logic         bn;
    exp_t         e;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    exp_t got;
    int   lat, busy;
    //        op     a         b         ai    bn     r          z     o     c
    v[0] = '{3'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    v[1] = '{3'd2, 16'h1234, 16'h1234, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    v[2] = '{3'd3, 16'hFFFF, 16'h0001, 1'b0, 1'b1, '{16'h0001, 1'b0, 1'b0, 1'b1}};
    v[3] = '{3'd3, 16'h0001, 16'hFFFF, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b0}};
    v[4] = '{3'd6, 16'h8001, 16'h0001, 1'b0, 1'b0, '{16'hC000, 1'b0, 1'b0, 1'b1}};
    v[5] = '{3'd4, 16'h1234, 16'h0000, 1'b0, 1'b0, '{16'h1234, 1'b0, 1'b0, 1'b0}};
    v[6] = '{3'd0, 16'h00F0, 16'h0FF0, 1'b1, 1'b0, '{16'h0F00, 1'b0, 1'b0, 1'b0}};
    v[7] = '{3'd5, 16'h8001, 16'h0010, 1'b1, 1'b1, '{16'h8001, 1'b0, 1'b0, 1'b0}};
    drain();
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].ai, v[i].bn, got, lat, busy);
      checks++;
      if (got !== v[i].e || lat != 1) begin
        errors++;
        $display("FAIL directed[%0d]: got R=%h Z=%b O=%b C=%b lat=%0d, want R=%h Z=%b O=%b C=%b lat=1",
                 i, got.r, got.z, got.o, got.c, lat, v[i].e.r, v[i].e.z, v[i].e.o, v[i].e.c);
      end
    end
  endtask

  task automatic test_mul();
    exp_t got;
    int   lat, busy;
    drain();
    do_op(3'd7, 16'h0100, 16'h0101, 1'b0, 1'b0, got, lat, busy);
    checks++;
`ifdef ALU_SEQ_MUL_EN
    if (got !== {16'h0100, 1'b0, 1'b0, 1'b1} || lat != 17 || busy != 0) begin
      errors++;
      $display("FAIL mul: got R=%h Z=%b O=%b C=%b lat=%0d busy=%0d, want R=0100 Z=0 O=0 C=1 lat=17 busy=0",
               got.r, got.z, got.o, got.c, lat, busy);
    end
`else
    if (got !== {16'h0000, 1'b1, 1'b0, 1'b0} || lat != 1) begin
      errors++;
      $display("FAIL op7_disabled: got R=%h Z=%b O=%b C=%b lat=%0d, want R=0000 Z=1 O=0 C=0 lat=1",
               got.r, got.z, got.o, got.c, lat);
    end
`endif
  endtask

  task automatic test_random();
    exp_t got, e;
    int   lat, busy;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         ai, bn;
    drain();
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) b[3:0] = 4'h0;
      if ($urandom_range(0, 7) == 0) a = {1'b0, {(W-1){1'b1}}};
      ai = 1'($urandom);
      bn = 1'($urandom);
      e  = model(op, a, b, ai, bn);
      do_op(op, a, b, ai, bn, got, lat, busy);
      checks++;
      if (got !== e || lat != exp_lat(op) || busy != 0) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h ai=%b bn=%b: got R=%h Z=%b O=%b C=%b lat=%0d busy=%0d, want R=%h Z=%b O=%b C=%b lat=%0d",
                 i, op, a, b, ai, bn, got.r, got.z, got.o, got.c, lat, busy,
                 e.r, e.z, e.o, e.c, exp_lat(op));
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t prev, e;
    logic [2:0] op;
    drain();
    OutReady = 1'b1;
    prev = '0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        checks++;
        if (OutValid !== 1'b1 || InReady !== 1'b1 || {Result, Zero, Overflow, CarryOut} !== prev) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got V=%b RDY=%b R=%h Z=%b O=%b C=%b, want V=1 RDY=1 R=%h Z=%b O=%b C=%b",
                   i, OutValid, InReady, Result, Zero, Overflow, CarryOut, prev.r, prev.z, prev.o, prev.c);
        end
      end
      if (i == 20) break;
      op = 3'($urandom_range(0, 6));
      A = W'($urandom); B = W'($urandom);
      AInvert = 1'($urandom); BNegate = 1'($urandom);
      ALUOp = op; InValid = 1'b1;
      e = model(op, A, B, AInvert, BNegate);
      prev = e;
      @(negedge Clock);
    end
    InValid = 1'b0;
  endtask

  task automatic test_backpressure();
    drain();
    OutReady = 1'b0;
    ALUOp = 3'd2; A = 16'h7FFF; B = 16'h0001; AInvert = 1'b0; BNegate = 1'b0; InValid = 1'b1;
    @(negedge Clock);
    // Keep offering a different op while the result is stalled.
    ALUOp = 3'd0; A = 16'h0000; B = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({OutValid, InReady, Result, Zero, Overflow, CarryOut} !== {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL backpressure[%0d]: got V=%b RDY=%b R=%h Z=%b O=%b C=%b, want V=1 RDY=0 R=8000 Z=0 O=1 C=0",
                 i, OutValid, InReady, Result, Zero, Overflow, CarryOut);
      end
      @(negedge Clock);
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(negedge Clock);
    checks++;
    if (OutValid !== 1'b0 || Result !== 16'h8000) begin
      errors++;
      $display("FAIL backpressure_release: got V=%b R=%h, want V=0 R=8000", OutValid, Result);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    drain();
`ifdef ALU_SEQ_MUL_EN
    ALUOp = 3'd7; A = 16'h0100; B = 16'h0101; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    repeat (7) @(negedge Clock);
`else
    OutReady = 1'b0;
    ALUOp = 3'd2; A = 16'h1111; B = 16'h2222; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    repeat (2) @(negedge Clock);
`endif
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    OutReady = 1'b1;
    checks++;
    if ({OutValid, Result, Zero, InReady} !== {1'b0, {W{1'b0}}, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got V=%b R=%h Z=%b RDY=%b, want V=0 R=0000 Z=1 RDY=1",
               OutValid, Result, Zero, InReady);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (OutValid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_stale: got %0d cycles with OutValid after reset, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
